// File: rtl/cipher_rr_scheduler_if.sv
// Request/response/cipher bundle for the round-robin cipher scheduler.
// The master side is the stream front ends plus cipher core; the slave side is the scheduler.
interface cipher_rr_scheduler_if #(
  parameter int N_CH = 2
) ();
  localparam int CHW = (N_CH > 2) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]   req_valid;
  logic [N_CH-1:0]   req_ready;
  logic [8*N_CH-1:0] req_char;
  logic [8*N_CH-1:0] req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_char;
  logic [CHW-1:0]    rsp_ch;
  logic              rsp_err;
  logic              cph_din_valid;
  logic [7:0]        cph_key;
  logic [7:0]        cph_char;
  logic [7:0]        cph_dout;
  logic              cph_dout_ready;

  modport master (
    output req_valid, req_char, req_key, rsp_ready, cph_dout, cph_dout_ready,
    input  req_ready, rsp_valid, rsp_char, rsp_ch, rsp_err,
           cph_din_valid, cph_key, cph_char
  );

  modport slave (
    input  req_valid, req_char, req_key, rsp_ready, cph_dout, cph_dout_ready,
    output req_ready, rsp_valid, rsp_char, rsp_ch, rsp_err,
           cph_din_valid, cph_key, cph_char
  );
endinterface

// File: rtl/cipher_rr_scheduler.sv
// Round-robin arbiter sharing one stream-cipher core between N_CH channels.
// Letters are sent through the cipher; other characters are echoed back directly.
module cipher_rr_scheduler #(
  parameter int N_CH        = 2,
  parameter int TIMEOUT_CYC = 4
) (
  input logic                  clk,
  input logic                  rst,
  cipher_rr_scheduler_if.slave bus_if
);
  localparam int CHW = (N_CH > 2) ? $clog2(N_CH) : 1;
  localparam int TW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e          state_q;
  logic [CHW-1:0]  ptr_q;
  logic [CHW-1:0]  ch_q;
  logic [TW-1:0]   timer_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_char_q;
  logic [CHW-1:0]  rsp_ch_q;
  logic            rsp_err_q;
  logic            cph_din_valid_q;
  logic [7:0]      cph_key_q;
  logic [7:0]      cph_char_q;

  logic            grant_found_s;
  logic [CHW-1:0]  grant_idx_s;
  logic [N_CH-1:0] req_ready_s;
  logic [7:0]      sel_char_s;
  logic [7:0]      sel_key_s;
  int              idx_v;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  // Grant search: scan downward so the channel closest to ptr_q wins last.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    idx_v         = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx_v = int'(ptr_q) + i;
      if (idx_v >= N_CH) begin
        idx_v = idx_v - N_CH;
      end else begin
        idx_v = idx_v;
      end
      if (bus_if.req_valid[CHW'(idx_v)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = CHW'(idx_v);
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // One-hot accept, gated by reset so nothing is accepted while rst is high.
  always_comb begin
    req_ready_s = '0;
    if ((state_q == IDLE) && grant_found_s && !rst) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  assign sel_char_s = bus_if.req_char[8*grant_idx_s +: 8];
  assign sel_key_s  = bus_if.req_key[8*grant_idx_s +: 8];

  // Main FSM; all response and cipher-side outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      ch_q            <= '0;
      timer_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_char_q      <= 8'h00;
      rsp_ch_q        <= '0;
      rsp_err_q       <= 1'b0;
      cph_din_valid_q <= 1'b0;
      cph_key_q       <= 8'h00;
      cph_char_q      <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found_s) begin
            ch_q <= grant_idx_s;
            if (is_letter(sel_char_s)) begin
              state_q         <= ISSUE;
              cph_din_valid_q <= 1'b1;
              cph_char_q      <= sel_char_s;
              cph_key_q       <= sel_key_s;
            end else begin
              state_q     <= HOLD;
              rsp_valid_q <= 1'b1;
              rsp_char_q  <= sel_char_s;
              rsp_ch_q    <= grant_idx_s;
              rsp_err_q   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          cph_din_valid_q <= 1'b0;
          timer_q         <= '0;
          state_q         <= WAIT;
        end
        WAIT: begin
          if (bus_if.cph_dout_ready || (timer_q == TW'(TIMEOUT_CYC - 1))) begin
            state_q     <= HOLD;
            rsp_valid_q <= 1'b1;
            rsp_ch_q    <= ch_q;
            rsp_err_q   <= !bus_if.cph_dout_ready;
            rsp_char_q  <= bus_if.cph_dout_ready ? bus_if.cph_dout : cph_char_q;
            cph_char_q  <= 8'h00;
            cph_key_q   <= 8'h00;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        HOLD: begin
          if (bus_if.rsp_ready) begin
            state_q     <= IDLE;
            ptr_q       <= (ch_q == CHW'(N_CH - 1)) ? '0 : ch_q + CHW'(1);
            rsp_valid_q <= 1'b0;
            rsp_char_q  <= 8'h00;
            rsp_ch_q    <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.req_ready     = req_ready_s;
  assign bus_if.rsp_valid     = rsp_valid_q;
  assign bus_if.rsp_char      = rsp_char_q;
  assign bus_if.rsp_ch        = rsp_ch_q;
  assign bus_if.rsp_err       = rsp_err_q;
  assign bus_if.cph_din_valid = cph_din_valid_q;
  assign bus_if.cph_key       = cph_key_q;
  assign bus_if.cph_char      = cph_char_q;
endmodule

// File: tb/tb_cipher_rr_scheduler.sv
// Directed bench for cipher_rr_scheduler with a one-cycle XOR cipher stub.
module tb_cipher_rr_scheduler;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub_en = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  cipher_rr_scheduler_if #(.N_CH(2)) bus ();

  cipher_rr_scheduler #(.N_CH(2), .TIMEOUT_CYC(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  // Cipher stub: result is char ^ key, ready one cycle after din_valid.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cph_dout_ready <= 1'b0;
      bus.cph_dout       <= 8'h00;
    end else begin
      bus.cph_dout_ready <= stub_en & bus.cph_din_valid;
      bus.cph_dout       <= bus.cph_char ^ bus.cph_key;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input int ch);
    #1;
    check_val("grant", 32'(bus.req_ready), 32'(1 << ch));
    tick();
  endtask

  // Called in the cycle after accept; returns in the HOLD cycle.
  task automatic wait_rsp(input int ch, input logic [7:0] c, input logic [7:0] k,
                          input logic [7:0] exp_char, input logic exp_err, input int exp_lat);
    int lat = 1;
    int pulses = 0;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.cph_din_valid) begin
        pulses++;
        check_val("cph_char", 32'(bus.cph_char), 32'(c));
        check_val("cph_key", 32'(bus.cph_key), 32'(k));
      end
      tick();
      lat++;
    end
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("pulses", 32'(pulses), (exp_lat == 1) ? 32'd0 : 32'd1);
    check_val("rsp_char", 32'(bus.rsp_char), 32'(exp_char));
    check_val("rsp_ch", 32'(bus.rsp_ch), 32'(ch));
    check_val("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
  endtask

  task automatic txn(input int ch, input logic [7:0] c, input logic [7:0] k,
                     input logic [7:0] exp_char, input logic exp_err, input int exp_lat);
    bus.req_char[8*ch +: 8] = c;
    bus.req_key[8*ch +: 8]  = k;
    bus.req_valid[ch]       = 1'b1;
    accept(ch);
    bus.req_valid[ch] = 1'b0;
    wait_rsp(ch, c, k, exp_char, exp_err, exp_lat);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] nl [5];
    logic [7:0] l0 [4];
    logic [7:0] l1 [4];
    int         idx [2];
    logic [7:0] cur;
    logic [7:0] kk;

    nl = '{8'h20, 8'h40, 8'h5B, 8'h60, 8'h7B};
    l0 = '{8'h41, 8'h5A, 8'h61, 8'h7A};
    l1 = '{8'h4D, 8'h62, 8'h59, 8'h6E};

    bus.req_valid = 2'b00;
    bus.req_char  = 16'h0000;
    bus.req_key   = 16'h0000;
    bus.rsp_ready = 1'b1;

    // Reset state, with requests present.
    repeat (2) tick();
    bus.req_valid = 2'b11;
    #1;
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("rst_cph_valid", 32'(bus.cph_din_valid), 32'd0);
    check_val("rst_rsp_char", 32'(bus.rsp_char), 32'd0);
    bus.req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // Move ptr to 1 with a non-letter on ch0.
    txn(0, 8'h2A, 8'h00, 8'h2A, 1'b0, 1);

    // Test 1: reset during WAIT.
    stub_en = 1'b0;
    bus.req_char[15:8] = 8'h4D;
    bus.req_key[15:8]  = 8'h77;
    bus.req_valid      = 2'b10;
    accept(1);
    bus.req_valid = 2'b00;
    check_val("t1_issue", 32'(bus.cph_din_valid), 32'd1);
    tick();
    check_val("t1_wait_char", 32'(bus.cph_char), 32'h4D);
    bus.req_char[7:0] = 8'h41;
    bus.req_key[7:0]  = 8'h2B;
    bus.req_valid     = 2'b11;
    rst = 1'b1;
    #1;
    check_val("t1_cph_char0", 32'(bus.cph_char), 32'd0);
    check_val("t1_cph_key0", 32'(bus.cph_key), 32'd0);
    check_val("t1_cph_valid0", 32'(bus.cph_din_valid), 32'd0);
    check_val("t1_req_ready0", 32'(bus.req_ready), 32'd0);
    check_val("t1_rsp_valid0", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    stub_en = 1'b1;

    // Test 2: 'A' with key 2B on ch0; first grant after reset is ch0.
    accept(0);
    bus.req_valid = 2'b00;
    wait_rsp(0, 8'h41, 8'h2B, 8'h6A, 1'b0, 3);
    tick();

    // Test 3: non-letters on ch1 echo after one cycle.
    for (int i = 0; i < 5; i++) begin
      txn(1, nl[i], 8'h99, nl[i], 1'b0, 1);
    end

    // Test 4: both channels hold four letters; grants alternate.
    idx[0] = 0;
    idx[1] = 0;
    bus.req_char  = {l1[0], l0[0]};
    bus.req_key   = {8'hC3, 8'h2B};
    bus.req_valid = 2'b11;
    for (int n = 0; n < 8; n++) begin
      int ch;
      ch  = n % 2;
      cur = (ch == 0) ? l0[idx[0]] : l1[idx[1]];
      kk  = (ch == 0) ? 8'h2B : 8'hC3;
      accept(ch);
      idx[ch]++;
      if (idx[ch] < 4) begin
        bus.req_char[8*ch +: 8] = (ch == 0) ? l0[idx[0]] : l1[idx[1]];
      end else begin
        bus.req_valid[ch] = 1'b0;
      end
      wait_rsp(ch, cur, kk, cur ^ kk, 1'b0, 3);
      tick();
    end

    // Test 5: backpressure in HOLD for 5 cycles.
    bus.rsp_ready = 1'b0;
    bus.req_char[15:8] = 8'h7A;
    bus.req_key[15:8]  = 8'h5A;
    bus.req_valid      = 2'b10;
    accept(1);
    bus.req_valid = 2'b00;
    wait_rsp(1, 8'h7A, 8'h5A, 8'h20, 1'b0, 3);
    bus.req_char[7:0] = 8'h6B;
    bus.req_key[7:0]  = 8'h0F;
    bus.req_valid     = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("bp_rsp_char", 32'(bus.rsp_char), 32'h20);
      check_val("bp_rsp_ch", 32'(bus.rsp_ch), 32'd1);
      check_val("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check_val("bp_cph_valid", 32'(bus.cph_din_valid), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(bus.req_ready), 32'd0);
    tick();
    accept(0);
    bus.req_valid = 2'b00;
    wait_rsp(0, 8'h6B, 8'h0F, 8'h64, 1'b0, 3);
    tick();

    // Test 6: cipher never answers -> timeout error with original char.
    stub_en = 1'b0;
    txn(0, 8'h51, 8'h33, 8'h51, 1'b1, 2 + TO);
    stub_en = 1'b1;
    txn(1, 8'h4B, 8'h01, 8'h4A, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
